// File: rtl/sar_adc_ctrl_if.sv
// Board-side bundle of the SAR ADC sequencer: trigger/mode controls,
// comparator input, DAC drive and the conversion result toward consumers.
interface sar_adc_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             continuous;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overrun;

  // Board / consumer side
  modport master (
    output start,
    output continuous,
    output cmp_in,
    input  dac_code,
    input  busy,
    input  done,
    input  result,
    input  overrun
  );

  // Sequencer side
  modport slave (
    input  start,
    input  continuous,
    input  cmp_in,
    output dac_code,
    output busy,
    output done,
    output result,
    output overrun
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation sequencer for an R-2R DAC plus external comparator.
// Binary-searches the DAC code one bit per step, waiting SETTLE_CYCLES before
// each comparator decision; single-shot or periodic triggering.
// Optional feature macro: AVG4_EN -- each trigger runs four back-to-back
// conversions and reports their truncated mean.
module sar_adc_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned SAMPLE_PERIOD = 100000
) (
  input  logic          clk,
  input  logic          reset,
  sar_adc_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);

  localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
  localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [WIDTH-1:0] CODE_MSB   = {1'b1, {(WIDTH-1){1'b0}}};

  // Parameter sanity checks at elaboration
  if (WIDTH < 2) begin : g_width_chk
    $error("sar_adc_ctrl: WIDTH must be >= 2");
  end
  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("sar_adc_ctrl: SETTLE_CYCLES must be >= 3");
  end
  if (SAMPLE_PERIOD < 2) begin : g_period_chk
    $error("sar_adc_ctrl: SAMPLE_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECIDE,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [SET_W-1:0] set_cnt_q;
  logic [PER_W-1:0] per_cnt_q;
  logic [1:0]       cmp_sync_q;
  logic             pending_q;
  logic [WIDTH-1:0] dac_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;

  logic             tick_c;
  logic             trigger_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] code_dec_c;

`ifdef AVG4_EN
  localparam int unsigned ACC_W = WIDTH + 2;
  logic [ACC_W-1:0] acc_q;
  logic [1:0]       conv_q;
  logic [ACC_W-1:0] sum_c;
`endif

  // Period tick, trigger qualification and the bit decision of the current step
  assign tick_c     = bus.continuous && (per_cnt_q == '0);
  assign trigger_c  = (state_q == ST_IDLE) && (bus.start || pending_q);
  assign bit_c      = WIDTH'(1) << idx_q;
  assign code_dec_c = cmp_sync_q[1] ? dac_q : (dac_q & ~bit_c);

`ifdef AVG4_EN
  assign sum_c = acc_q + ACC_W'(code_dec_c);
`endif

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_sync_q <= 2'b00;
    end else begin
      cmp_sync_q <= {cmp_sync_q[0], bus.cmp_in};
    end
  end

  // Free-running period counter, parked at its reload value outside continuous mode
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt_q <= PER_RELOAD;
    end else if (!bus.continuous || (per_cnt_q == '0)) begin
      per_cnt_q <= PER_RELOAD;
    end else begin
      per_cnt_q <= per_cnt_q - PER_W'(1);
    end
  end

  // Pending trigger and sticky overrun: a tick that finds an unconsumed trigger is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (!bus.continuous) begin
        pending_q <= 1'b0;
      end else if (tick_c) begin
        pending_q <= 1'b1;
      end else if (trigger_c) begin
        pending_q <= 1'b0;
      end
      if (tick_c && pending_q && !trigger_c) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Conversion sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      set_cnt_q <= '0;
      dac_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef AVG4_EN
      acc_q     <= '0;
      conv_q    <= 2'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trigger_c) begin
            idx_q     <= IDX_MSB;
            dac_q     <= CODE_MSB;
            set_cnt_q <= SET_RELOAD;
            busy_q    <= 1'b1;
            state_q   <= ST_SETTLE;
`ifdef AVG4_EN
            acc_q     <= '0;
            conv_q    <= 2'd0;
`endif
          end
        end

        ST_SETTLE: begin
          if (set_cnt_q == '0) begin
            state_q <= ST_DECIDE;
          end else begin
            set_cnt_q <= set_cnt_q - SET_W'(1);
          end
        end

        ST_DECIDE: begin
          if (idx_q == '0) begin
            dac_q   <= code_dec_c;
            state_q <= ST_DONE;
`ifdef AVG4_EN
            if (conv_q == 2'd3) begin
              result_q <= sum_c[ACC_W-1:2];
              done_q   <= 1'b1;
            end else begin
              acc_q <= sum_c;
            end
`else
            result_q <= code_dec_c;
            done_q   <= 1'b1;
`endif
          end else begin
            // Keep/clear the current bit and trial-set the next lower one
            dac_q     <= code_dec_c | (bit_c >> 1);
            idx_q     <= idx_q - IDX_W'(1);
            set_cnt_q <= SET_RELOAD;
            state_q   <= ST_SETTLE;
          end
        end

        ST_DONE: begin
`ifdef AVG4_EN
          if (conv_q != 2'd3) begin
            // Restart the next of the four conversions without an IDLE gap
            conv_q    <= conv_q + 2'd1;
            idx_q     <= IDX_MSB;
            dac_q     <= CODE_MSB;
            set_cnt_q <= SET_RELOAD;
            state_q   <= ST_SETTLE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
`else
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`endif
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dac_code = dac_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl (default build): WIDTH=8, SETTLE_CYCLES=4,
// comparator modelled as cmp_in = (vin >= dac_code). Two instances share the
// clock: SAMPLE_PERIOD=50 for most tests, SAMPLE_PERIOD=20 for overrun.
module tb_sar_adc_ctrl;

  logic clk;
  logic reset;
  logic [7:0] vin0;
  logic [7:0] vin1;

  int cyc;
  int n_checks;
  int n_errors;
  logic [7:0] trace_got [8];

  localparam logic [7:0] FF_TRACE [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0,
                                          8'hF8, 8'hFC, 8'hFE, 8'hFF};

  sar_adc_ctrl_if #(.WIDTH(8)) bus0 ();
  sar_adc_ctrl_if #(.WIDTH(8)) bus1 ();

  sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4), .SAMPLE_PERIOD(50)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4), .SAMPLE_PERIOD(20)) u_dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus0.cmp_in = (vin0 >= bus0.dac_code);
  assign bus1.cmp_in = (vin1 >= bus1.dac_code);

  always #5 clk = ~clk;

  // Count one comparison, report a mismatch
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive start during cycle 0; returns in cycle 1
  task automatic fire_start();
    cyc = 0;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
  endtask

  // Observe instance 0 through cycle max_cyc: done count/first cycle, busy vs window 1..exp_done
  task automatic watch_conv(input int max_cyc, input int exp_done, input bit repulse,
                            input bit trace_en, output int first_done, output int n_done,
                            output int busy_bad);
    first_done = -1;
    n_done     = 0;
    busy_bad   = 0;
    while (cyc <= max_cyc) begin
      bus0.start = repulse && (cyc == 10 || cyc == 30);
      if (bus0.done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
      if (bus0.busy !== ((cyc >= 1) && (cyc <= exp_done))) busy_bad++;
      if (trace_en && cyc <= 36 && (cyc % 5) == 1) trace_got[cyc/5] = bus0.dac_code;
      step();
    end
    bus0.start = 1'b0;
  endtask

  // Wait (bounded) for instance 0 to leave a conversion
  task automatic wait_idle0(input int max_cyc);
    int n;
    n = 0;
    while (bus0.busy && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("idle0_bound", 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd, nd, bb;
    int dones [$];
    int res_bad, ov_bad;

    clk = 1'b0;
    reset = 1'b1;
    vin0 = 8'h00;
    vin1 = 8'h00;
    bus0.start = 1'b0;
    bus0.continuous = 1'b0;
    bus1.start = 1'b0;
    bus1.continuous = 1'b0;
    n_checks = 0;
    n_errors = 0;
    cyc = 0;

    // Reset state
    step(); step(); step();
    reset = 1'b0;
    step();
    check_eq("rst_dac",     32'(bus0.dac_code), 32'h00);
    check_eq("rst_busy",    32'(bus0.busy),     32'd0);
    check_eq("rst_done",    32'(bus0.done),     32'd0);
    check_eq("rst_result",  32'(bus0.result),   32'h00);
    check_eq("rst_overrun", 32'(bus0.overrun),  32'd0);
    check_eq("rst_busy_f",  32'(bus1.busy),     32'd0);
    check_eq("rst_ovr_f",   32'(bus1.overrun),  32'd0);

    // vin=A5 single shot: busy 1..41, done only at 41
    vin0 = 8'hA5;
    fire_start();
    watch_conv(80, 41, 1'b0, 1'b0, fd, nd, bb);
    check_eq("a5_done_cyc", 32'(fd), 32'd41);
    check_eq("a5_done_cnt", 32'(nd), 32'd1);
    check_eq("a5_busy_bad", 32'(bb), 32'd0);
    check_eq("a5_result",   32'(bus0.result), 32'hA5);

    // vin=00
    vin0 = 8'h00;
    fire_start();
    watch_conv(60, 41, 1'b0, 1'b0, fd, nd, bb);
    check_eq("z_done_cyc", 32'(fd), 32'd41);
    check_eq("z_result",   32'(bus0.result), 32'h00);

    // vin=FF with DAC trace at the first SETTLE cycle of each bit
    vin0 = 8'hFF;
    fire_start();
    watch_conv(60, 41, 1'b0, 1'b1, fd, nd, bb);
    check_eq("ff_done_cyc", 32'(fd), 32'd41);
    check_eq("ff_result",   32'(bus0.result), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("ff_trace%0d", i), 32'(trace_got[i]), 32'(FF_TRACE[i]));
    end

    // start re-pulsed at cycles 10 and 30 is ignored
    vin0 = 8'h5A;
    fire_start();
    watch_conv(100, 41, 1'b1, 1'b0, fd, nd, bb);
    check_eq("rep_done_cyc", 32'(fd), 32'd41);
    check_eq("rep_done_cnt", 32'(nd), 32'd1);
    check_eq("rep_busy_bad", 32'(bb), 32'd0);
    check_eq("rep_result",   32'(bus0.result), 32'h5A);

    // Reset for one cycle at cycle 20 mid-conversion
    vin0 = 8'hC3;
    fire_start();
    while (cyc < 20) step();
    reset = 1'b1;
    step();
    check_eq("mid_rst_dac",    32'(bus0.dac_code), 32'h00);
    check_eq("mid_rst_busy",   32'(bus0.busy),     32'd0);
    check_eq("mid_rst_result", 32'(bus0.result),   32'h00);
    reset = 1'b0;
    watch_conv(140, 0, 1'b0, 1'b0, fd, nd, bb);
    check_eq("mid_rst_no_done", 32'(nd), 32'd0);
    check_eq("mid_rst_busy_bad", 32'(bb), 32'd0);

    // Continuous, SAMPLE_PERIOD=50: ticks at end of cycles 49,99,...; done at 91,141,191,241
    vin0 = 8'h3C;
    cyc = 0;
    bus0.continuous = 1'b1;
    res_bad = 0;
    ov_bad = 0;
    dones.delete();
    while (cyc <= 250) begin
      if (bus0.done === 1'b1) begin
        dones.push_back(cyc);
        if (bus0.result !== 8'h3C) res_bad++;
      end
      if (bus0.overrun !== 1'b0) ov_bad++;
      step();
    end
    bus0.continuous = 1'b0;
    check_eq("cont_done_cnt", 32'(dones.size()), 32'd4);
    if (dones.size() == 4) begin
      check_eq("cont_first", 32'(dones[0]), 32'd91);
      for (int i = 1; i < 4; i++) begin
        check_eq($sformatf("cont_gap%0d", i), 32'(dones[i] - dones[i-1]), 32'd50);
      end
    end
    check_eq("cont_res_bad", 32'(res_bad), 32'd0);
    check_eq("cont_ovr_bad", 32'(ov_bad), 32'd0);
    wait_idle0(100);

    // Continuous, SAMPLE_PERIOD=20: ticks every 20 cycles, conversions back-to-back
    // (done at 61,103,145,187), a tick at end of cycle 59 finds pending set
    vin1 = 8'h77;
    cyc = 0;
    bus1.continuous = 1'b1;
    res_bad = 0;
    dones.delete();
    while (cyc <= 200) begin
      if (bus1.done === 1'b1) begin
        dones.push_back(cyc);
        if (bus1.result !== 8'h77) res_bad++;
      end
      if (cyc == 40) check_eq("fast_ovr_early", 32'(bus1.overrun), 32'd0);
      if (cyc == 60) check_eq("fast_ovr_set",   32'(bus1.overrun), 32'd1);
      step();
    end
    bus1.continuous = 1'b0;
    check_eq("fast_done_cnt", 32'(dones.size()), 32'd4);
    if (dones.size() == 4) begin
      check_eq("fast_first", 32'(dones[0]), 32'd61);
      for (int i = 1; i < 4; i++) begin
        check_eq($sformatf("fast_gap%0d", i), 32'(dones[i] - dones[i-1]), 32'd42);
      end
    end
    check_eq("fast_res_bad",  32'(res_bad), 32'd0);
    check_eq("fast_ovr_held", 32'(bus1.overrun), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
